// File: rtl/cska_pkg.sv
// Shared configuration helpers for the pipelined carry-skip adder/subtractor.
package cska_pkg;

  function automatic int unsigned calc_blocks(int unsigned n, int unsigned block_size);
    return n / block_size;
  endfunction

  function automatic int unsigned calc_bps(int unsigned blocks, int unsigned stages);
    return blocks / stages;
  endfunction

  // True when the width splits into whole blocks and the blocks split evenly across stages.
  function automatic bit cfg_ok(int unsigned n, int unsigned block_size, int unsigned stages);
    return (n > 0) && (block_size > 0) && (stages > 0) &&
           (n % block_size == 0) && ((n / block_size) % stages == 0);
  endfunction

endpackage

// File: rtl/cla_block.sv
// One carry-lookahead block: slice sum for a given carry-in, plus the block
// generate-carry (carry-out assuming carry-in 0) and the block propagate.
module cla_block #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         g_o,
  output logic         p_o
);

  logic [W-1:0] gen_bit;
  logic [W-1:0] prop_bit;
  logic [W-1:0] carry;
  logic [W:0]   gen_carry;

  // NOTE: every variable written in always_comb gets a value before any
  // conditional or loop touches it, so no path can leave a latch behind.
  always_comb begin
    gen_bit      = a_i & b_i;
    prop_bit     = a_i ^ b_i;
    carry        = '0;
    gen_carry    = '0;
    carry[0]     = c_i;
    for (int i = 0; i < W - 1; i++) begin
      carry[i+1] = gen_bit[i] | (prop_bit[i] & carry[i]);
    end
    for (int i = 0; i < W; i++) begin
      gen_carry[i+1] = gen_bit[i] | (prop_bit[i] & gen_carry[i]);
    end
  end

  assign s_o = prop_bit ^ carry;
  assign g_o = gen_carry[W];
  assign p_o = &prop_bit;

endmodule

// File: rtl/cska_pipe_stage.sv
// One pipeline stage: resolves BPS skip blocks of the running sum and
// registers the result behind a valid/ready handshake.
module cska_pipe_stage #(
  parameter int unsigned N          = 16,
  parameter int unsigned BLOCK_SIZE = 4,
  parameter int unsigned BPS        = 2,
  parameter int unsigned STAGE_IDX  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid_i,
  output logic         up_ready_o,
  input  logic [N-1:0] up_psum_i,
  input  logic [N-1:0] up_a_i,
  input  logic [N-1:0] up_b_i,
  input  logic         up_carry_i,
  input  logic         dn_ready_i,
  output logic         dn_valid_o,
  output logic [N-1:0] dn_psum_o,
  output logic [N-1:0] dn_a_o,
  output logic [N-1:0] dn_b_o,
  output logic         dn_carry_o
);

  localparam int unsigned SW = BPS * BLOCK_SIZE;
  localparam int unsigned LO = STAGE_IDX * SW;

  typedef struct packed {
    logic         valid;
    logic [N-1:0] psum;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         carry;
  } stage_t;

  stage_t        stage_q, stage_d;
  logic [BPS:0]  blk_c;
  logic [BPS-1:0] blk_g, blk_p;
  logic [SW-1:0] slice_sum;
  logic          advance;

  assign blk_c[0] = up_carry_i;

  for (genvar j = 0; j < BPS; j++) begin : g_block
    cla_block #(.W(BLOCK_SIZE)) u_cla (
      .a_i (up_a_i[LO + j*BLOCK_SIZE +: BLOCK_SIZE]),
      .b_i (up_b_i[LO + j*BLOCK_SIZE +: BLOCK_SIZE]),
      .c_i (blk_c[j]),
      .s_o (slice_sum[j*BLOCK_SIZE +: BLOCK_SIZE]),
      .g_o (blk_g[j]),
      .p_o (blk_p[j])
    );
    // Skip mux: a fully propagating block passes its carry-in straight through.
    assign blk_c[j+1] = blk_p[j] ? blk_c[j] : blk_g[j];
  end

  assign advance    = !stage_q.valid || dn_ready_i;
  assign up_ready_o = advance;

  always_comb begin
    stage_d = stage_q;
    if (advance) begin
      stage_d.valid = up_valid_i;
      if (up_valid_i) begin
        stage_d.psum              = up_psum_i;
        stage_d.psum[LO +: SW]    = slice_sum;
        stage_d.a                 = up_a_i;
        stage_d.b                 = up_b_i;
        stage_d.carry             = blk_c[BPS];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its neighbour's pre-edge value. The datapath is reset along with the valid
  // bit because the last stage's fields are the visible sum/cout/ovf outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dn_valid_o = stage_q.valid;
  assign dn_psum_o  = stage_q.psum;
  assign dn_a_o     = stage_q.a;
  assign dn_b_o     = stage_q.b;
  assign dn_carry_o = stage_q.carry;

endmodule

// File: rtl/cska_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready on both sides.
// The carry chain is split evenly over STAGES registered stages.
module cska_pipe
  import cska_pkg::*;
#(
  parameter int unsigned N          = 16,
  parameter int unsigned BLOCK_SIZE = 4,
  parameter int unsigned STAGES     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned BLOCKS = calc_blocks(N, BLOCK_SIZE);
  localparam int unsigned BPS    = calc_bps(BLOCKS, STAGES);

  if (!cfg_ok(N, BLOCK_SIZE, STAGES)) begin : g_cfg_check
    $fatal(1, "cska_pipe: N must divide into BLOCK_SIZE blocks and the blocks evenly into STAGES");
  end

  // Index 0 is the incoming beat; index k+1 is the register of stage k.
  logic [STAGES:0][N-1:0] psum_w, a_w, b_w;
  logic [STAGES:0]        carry_w, valid_w, ready_w;
  logic                   unused_tail;

  assign psum_w[0]       = '0;
  assign a_w[0]          = a;
  assign b_w[0]          = sub ? ~b : b;
  assign carry_w[0]      = sub ? 1'b1 : cin;
  assign valid_w[0]      = in_valid;
  assign ready_w[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cska_pipe_stage #(
      .N          (N),
      .BLOCK_SIZE (BLOCK_SIZE),
      .BPS        (BPS),
      .STAGE_IDX  (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid_i (valid_w[k]),
      .up_ready_o (ready_w[k]),
      .up_psum_i  (psum_w[k]),
      .up_a_i     (a_w[k]),
      .up_b_i     (b_w[k]),
      .up_carry_i (carry_w[k]),
      .dn_ready_i (ready_w[k+1]),
      .dn_valid_o (valid_w[k+1]),
      .dn_psum_o  (psum_w[k+1]),
      .dn_a_o     (a_w[k+1]),
      .dn_b_o     (b_w[k+1]),
      .dn_carry_o (carry_w[k+1])
    );
  end

  assign in_ready  = ready_w[0] & ~rst;
  assign out_valid = valid_w[STAGES];
  assign sum       = psum_w[STAGES];
  assign cout      = carry_w[STAGES];
  assign ovf       = (a_w[STAGES][N-1] == b_w[STAGES][N-1]) &&
                     (psum_w[STAGES][N-1] != a_w[STAGES][N-1]);

  // Only the operand sign bits matter once the last stage has resolved the sum.
  assign unused_tail = ^{a_w[STAGES][N-2:0], b_w[STAGES][N-2:0]};

endmodule

// File: tb/tb_cska_pipe.sv
// Self-checking bench for cska_pipe (N=16, BLOCK_SIZE=4, STAGES=2): directed
// corner cases, backpressure, randomized traffic and reset while busy.
module tb_cska_pipe;

  localparam int unsigned N = 16;

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [N-1:0] a, b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [N-1:0] sum;
  logic         cout, ovf;

  res_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic acc, popd, seen_in_ready;

  always #5 clk = ~clk;

  cska_pipe #(.N(N), .BLOCK_SIZE(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic res_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                 input logic cv, input logic sv);
    int   ua, ub, sa, sb, r, sr;
    res_t o;
    ua = av;
    ub = bv;
    sa = $signed(av);
    sb = $signed(bv);
    if (sv) begin
      r      = ua - ub;
      sr     = sa - sb;
      o.cout = (ua >= ub);
    end else begin
      r      = ua + ub + int'(cv);
      sr     = sa + sb + int'(cv);
      o.cout = (r > 65535);
    end
    o.sum = r[N-1:0];
    o.ovf = (sr > 32767) || (sr < -32768);
    return o;
  endfunction

  function automatic logic [N-1:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'h0001;
      default: return N'($urandom);
    endcase
  endfunction

  // One clock: handshakes are judged at the falling edge, inputs change #1 after the rising edge.
  task automatic cycle();
    res_t e;
    acc  = 1'b0;
    popd = 1'b0;
    @(negedge clk);
    seen_in_ready = in_ready;
    if (out_valid && out_ready) begin
      popd = 1'b1;
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_sum",  32'(sum),  32'(e.sum));
        check("out_cout", 32'(cout), 32'(e.cout));
        check("out_ovf",  32'(ovf),  32'(e.ovf));
      end
    end
    if (in_valid && in_ready) begin
      acc = 1'b1;
      exp_q.push_back(model(a, b, cin, sub));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic cv, input logic sv,
                          input logic [N-1:0] es, input logic ec, input logic eo);
    a = av; b = bv; cin = cv; sub = sv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    check({tag, "_accept"}, 32'(acc), 32'd1);
    in_valid = 1'b0;
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    cycle();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(sum),  32'(es));
    check({tag, "_cout"},  32'(cout), 32'(ec));
    check({tag, "_ovf"},   32'(ovf),  32'(eo));
    cycle();
  endtask

  task automatic drain(input string tag);
    int guard;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      cycle();
      guard++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent, pops_win, stale;
    logic pending;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    directed("add_simple",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    directed("skip_carry",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("skip_cin",     16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("ovf_add",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_sub",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("sub_borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure: five beats offered back to back, consumer stalled for four cycles.
    sent = 0; pops_win = 0;
    a = rand_op(); b = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
    for (int c = 1; c <= 12; c++) begin
      out_ready = (c > 4);
      in_valid  = (sent < 5);
      cycle();
      if (acc) begin
        sent++;
        a = rand_op(); b = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
      end
      if (c == 3 || c == 4) check($sformatf("bp_in_ready_c%0d", c), 32'(seen_in_ready), 32'd0);
      if (c == 4) check("bp_capacity", 32'(sent), 32'd2);
      if (c >= 5 && c <= 9 && popd) pops_win++;
    end
    check("bp_sent",       32'(sent),         32'd5);
    check("bp_throughput", 32'(pops_win),     32'd5);
    check("bp_drained",    32'(exp_q.size()), 32'd0);
    in_valid = 1'b0;

    // Randomized traffic; an offered beat is held stable until it is taken.
    pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 9) < 7);
        a   = rand_op();
        b   = rand_op();
        cin = 1'($urandom);
        sub = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      pending = in_valid && !acc;
    end
    drain("rand_drain");

    // Reset with two beats in flight: both must vanish.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sent = 0;
    repeat (2) begin
      a = rand_op(); b = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
      cycle();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    check("rstmid_fill",      32'(sent),      32'd2);
    check("rstmid_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_sum",       32'(sum),       32'd0);
    check("rstmid_cout",      32'(cout),      32'd0);
    check("rstmid_ovf",       32'(ovf),       32'd0);
    check("rstmid_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (4) begin
      cycle();
      if (popd) stale++;
    end
    check("rstmid_no_stale", 32'(stale), 32'd0);
    directed("rstmid_fresh", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
